clock_disp_scan: RTL and testbench
==================================

Name: clock_disp_scan

Overview:
- Consumes the six BCD time digits produced by the clock core (h1 h2 : m1 m2 : s1 s2).
- Drives a 6-digit multiplexed 7-segment display, one digit at a time, at a programmable refresh rate.
- Snapshots all six digits once per scan frame, so a frame never mixes old and new time values (no tearing).
- Sits between the clock core and the board display pins.

Parameters:
- DIV, 1000, clk_out cycles each digit is lit (must be ≥2).
- SEG_ACTIVE_LOW, 1, when 1 the seg, dp and an outputs are active-low; when 0 they are active-high.
- BLINK_FRAMES, 64, frames per blink half-period (used only with BLINK_EN).

Ports:
- clk_out  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- en  in  1  scan enable.
- h1 h2 m1 m2 s1 s2  in  4 each  BCD digits from the clock core.
- blink_mask  in  6  per-digit blink request; bit0 = h1 … bit5 = s2.
- seg  out  7  segment bits {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, used as the colon.
- an  out  6  one-hot digit enable; bit0 = h1 (leftmost) … bit5 = s2.
- frame_start  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (rst=0 at a clk_out edge):
  - Prescaler, digit index and frame counter all = 0; shadow digits = 0.
  - an, seg and dp are all inactive (all-ones when SEG_ACTIVE_LOW=1); frame_start = 0.
- Prescaler:
  - Counts 0..DIV-1 while en=1.
  - On the DIV-1 to 0 wrap, the digit index advances 0→1→…→5→0.
- Frame boundary: the cycle with en=1, index=0 and prescaler=0.
  - All six inputs are latched into shadow registers.
  - frame_start goes high on the next cycle, for exactly one cycle.
- Output registers:
  - an, seg and dp are registered; in cycle t+1 they reflect the index and shadow contents of cycle t.
  - At the frame boundary, seg decodes the incoming h1 directly (bypass), so the new snapshot is visible from the first lit cycle.
- Decoding:
  - Active-high codes 0–9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - Any BCD value >9 gives a blank digit (all segments off); its an is still asserted.
- dp is asserted while index 1 (h2) or index 3 (m2) is lit; otherwise off.
- en=0:
  - The prescaler, index and shadow registers hold.
  - From the next cycle, an, seg and dp are all inactive.
  - When en returns to 1, scanning resumes at the same index and prescaler count; no snapshot is taken unless that cycle is a frame boundary.
- Reset mid-scan: the reset state applies at the next edge. After release, the first enabled cycle is a frame boundary.
- Inputs may change on any cycle; only values present at a frame-boundary cycle are displayed.

Optional Feature:
- Macro BLINK_EN.
- Defined:
  - A frame counter toggles blink_phase every BLINK_FRAMES frames; blink_phase = 0 after reset.
  - While blink_phase=1, any digit whose blink_mask bit is 1 is blanked (seg off, dp off, an still asserted).
  - blink_mask is sampled live, not snapshotted.
- Undefined: the frame counter is not built, blink_mask is ignored, and digits are never blanked for blinking.

Decomposition:
- Shared package clock_disp_pkg:
  - SEG_DIGIT[0:9] code constants and SEG_BLANK.
  - Digit index constants IDX_H1..IDX_S2.
  - Colon index constants.
- One sub-module, bcd_to_7seg: combinational decode from a 4-bit BCD value to 7 segment bits, active-high, blank for values >9. Polarity inversion is applied in the parent.

Test Plan (DIV=4, SEG_ACTIVE_LOW=1 unless stated):
- Reset: hold rst=0 for 2 cycles → an=6'b111111, seg=7'h7F, dp=1, frame_start=0. After release with en=1 → frame_start pulses once; an=6'b111110 for 4 cycles.
- Full scan with digits 1,2,3,4,5,6 → an walks 111110,111101,…,011111, each for 4 cycles. seg = ~06, ~5B, ~4F, ~66, ~6D, ~7D. dp=0 (active) only while bit1 and bit3 are lit. frame_start every 24 cycles.
- Tearing: change s2 from 6 to 7 while index 2 is lit → digit 5 still shows ~7D in that frame and ~07 in the next frame.
- Invalid BCD: m1=4'hC → while index 2 is lit, an bit2 is active and seg=7'h7F.
- Enable gap: drop en for 10 cycles during the 2nd cycle of index 3 → outputs are inactive for those cycles; after resuming, index 3 stays lit for its remaining 2 cycles, then index 4; no extra frame_start.
- Blink (BLINK_EN, BLINK_FRAMES=2, blink_mask=6'b110000) → s1 and s2 are blank in frames 2–3 and 6–7 and shown in frames 0–1 and 4–5. Same stimulus without the macro → s1 and s2 are never blank.

Source files
------------

// File: rtl/clock_disp_pkg.sv
// Shared constants for the 6-digit multiplexed display scanner:
// segment codes, digit index map and colon positions.
package clock_disp_pkg;

  typedef logic [2:0] digit_idx_t;

  localparam int NUM_DIGITS = 6;

  // Active-high segment codes {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam digit_idx_t IDX_H1 = 3'd0;
  localparam digit_idx_t IDX_H2 = 3'd1;
  localparam digit_idx_t IDX_M1 = 3'd2;
  localparam digit_idx_t IDX_M2 = 3'd3;
  localparam digit_idx_t IDX_S1 = 3'd4;
  localparam digit_idx_t IDX_S2 = 3'd5;

  // The colon is drawn with the dp of the digit left of each separator
  localparam digit_idx_t IDX_COLON_HM = IDX_H2;
  localparam digit_idx_t IDX_COLON_MS = IDX_M2;

  function automatic logic [5:0] idx_onehot(input digit_idx_t idx);
    idx_onehot = 6'b000001 << idx;
  endfunction

endpackage

// File: rtl/clock_disp_scan_bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder, active-high; values above 9
// decode to a blank digit.
module bcd_to_7seg
  import clock_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_disp_scan.sv
// Multiplexed 6-digit display scanner with per-frame snapshot of the time
// digits. Optional blinking of masked digits is built when BLINK_EN is defined.
module clock_disp_scan
  import clock_disp_pkg::*;
#(
  parameter int DIV            = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int BLINK_FRAMES   = 64
) (
  input  logic       clk_out,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] h1,
  input  logic [3:0] h2,
  input  logic [3:0] m1,
  input  logic [3:0] m2,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  input  logic [5:0] blink_mask,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_start
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [5:0] AN_OFF  = SEG_ACTIVE_LOW ? 6'h3F : 6'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [PW-1:0] presc_q, presc_d;
  digit_idx_t    idx_q, idx_d;
  logic [3:0]    shadow_q [NUM_DIGITS];
  logic [3:0]    shadow_d [NUM_DIGITS];
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [5:0]    an_q, an_d;
  logic          frame_start_q, frame_start_d;

  logic          boundary_s;
  logic          blank_s;
  logic [3:0]    cur_bcd_s;
  logic [6:0]    dec_seg_s;

  assign boundary_s = en && (idx_q == IDX_H1) && (presc_q == '0);

  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    for (int i = 0; i < NUM_DIGITS; i++) shadow_d[i] = shadow_q[i];
    if (en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_S2) ? IDX_H1 : idx_q + 3'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
      if (boundary_s) begin
        shadow_d[0] = h1;
        shadow_d[1] = h2;
        shadow_d[2] = m1;
        shadow_d[3] = m2;
        shadow_d[4] = s1;
        shadow_d[5] = s2;
      end
    end
  end

  // The boundary cycle shows the live h1 so the new snapshot appears at once
  always_comb begin
    case (idx_q)
      IDX_H1:  cur_bcd_s = boundary_s ? h1 : shadow_q[0];
      IDX_H2:  cur_bcd_s = shadow_q[1];
      IDX_M1:  cur_bcd_s = shadow_q[2];
      IDX_M2:  cur_bcd_s = shadow_q[3];
      IDX_S1:  cur_bcd_s = shadow_q[4];
      IDX_S2:  cur_bcd_s = shadow_q[5];
      default: cur_bcd_s = 4'hF;
    endcase
  end

  bcd_to_7seg u_dec (
    .bcd (cur_bcd_s),
    .seg (dec_seg_s)
  );

`ifdef BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  // Counter restarts at 1 so frame 0 after reset starts the first half-period
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (boundary_s) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES)) begin
        frame_cnt_d   = FW'(1);
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  assign blank_s = blink_phase_d & blink_mask[idx_q];

  always_ff @(posedge clk_out) begin
    if (!rst) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`else
  logic unused_blink_mask_s;
  assign unused_blink_mask_s = ^blink_mask;
  assign blank_s = 1'b0;
`endif

  always_comb begin
    an_d          = AN_OFF;
    seg_d         = SEG_OFF;
    dp_d          = DP_OFF;
    frame_start_d = boundary_s;
    if (en) begin
      an_d  = SEG_ACTIVE_LOW ? ~idx_onehot(idx_q) : idx_onehot(idx_q);
      seg_d = blank_s ? SEG_OFF : (SEG_ACTIVE_LOW ? ~dec_seg_s : dec_seg_s);
      if (!blank_s && (idx_q == IDX_COLON_HM || idx_q == IDX_COLON_MS)) begin
        dp_d = ~DP_OFF;
      end else begin
        dp_d = DP_OFF;
      end
    end
  end

  always_ff @(posedge clk_out) begin
    if (!rst) begin
      presc_q       <= '0;
      idx_q         <= IDX_H1;
      for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= 4'd0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      dp_q          <= DP_OFF;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= shadow_d[i];
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_clock_disp_scan.sv
// Directed self-checking bench for clock_disp_scan (DIV=4, active-low outputs).
module tb_clock_disp_scan;

  logic       clk_out = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] h1, h2, m1, m2, s1, s2;
  logic [5:0] blink_mask;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  clock_disp_scan #(
    .DIV            (4),
    .SEG_ACTIVE_LOW (1'b1),
    .BLINK_FRAMES   (2)
  ) dut (
    .clk_out     (clk_out),
    .rst         (rst),
    .en          (en),
    .h1          (h1),
    .h2          (h2),
    .m1          (m1),
    .m2          (m2),
    .s1          (s1),
    .s2          (s2),
    .blink_mask  (blink_mask),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk_out = ~clk_out;

  // Expected active-low segment pattern for a BCD value
  function automatic logic [6:0] exp_seg(input logic [3:0] v);
    logic [6:0] c;
    case (v)
      4'd0: c = 7'h3F;
      4'd1: c = 7'h06;
      4'd2: c = 7'h5B;
      4'd3: c = 7'h4F;
      4'd4: c = 7'h66;
      4'd5: c = 7'h6D;
      4'd6: c = 7'h7D;
      4'd7: c = 7'h07;
      4'd8: c = 7'h7F;
      4'd9: c = 7'h6F;
      default: c = 7'h00;
    endcase
    return ~c;
  endfunction

  function automatic logic [5:0] exp_an(input int idx);
    logic [5:0] one;
    one = 6'b000001;
    return ~(one << idx);
  endfunction

  task automatic step;
    @(posedge clk_out);
    #1;
  endtask

  task automatic set_digits(input logic [3:0] a, b, c, d, e, f);
    h1 = a; h2 = b; m1 = c; m2 = d; s1 = e; s2 = f;
  endtask

  task automatic test_reset;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    blink_mask = 6'b000000;
    rst = 1'b0;
    en  = 1'b0;
    step;
    step;
    checks++; if (an !== 6'b111111) begin errors++; $display("FAIL reset_an actual=%b required=%b", an, 6'b111111); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg actual=%h required=%h", seg, 7'h7F); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp actual=%b required=1", dp); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs actual=%b required=0", frame_start); end
    rst = 1'b1;
    en  = 1'b1;
    step;
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (frame_start !== (k == 0)) begin
        errors++; $display("FAIL release_fs k=%0d actual=%b required=%b", k, frame_start, (k == 0));
      end
      if (k < 4) begin
        checks++;
        if (an !== 6'b111110) begin errors++; $display("FAIL release_an k=%0d actual=%b required=111110", k, an); end
      end
      step;
    end
  endtask

  task automatic test_full_scan;
    logic [3:0] d [6];
    d[0] = 4'd1; d[1] = 4'd2; d[2] = 4'd3; d[3] = 4'd4; d[4] = 4'd5; d[5] = 4'd6;
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (an !== exp_an(k / 4)) begin errors++; $display("FAIL scan_an k=%0d actual=%b required=%b", k, an, exp_an(k / 4)); end
      checks++;
      if (seg !== exp_seg(d[k / 4])) begin errors++; $display("FAIL scan_seg k=%0d actual=%h required=%h", k, seg, exp_seg(d[k / 4])); end
      checks++;
      if (dp !== !((k / 4) == 1 || (k / 4) == 3)) begin errors++; $display("FAIL scan_dp k=%0d actual=%b", k, dp); end
      checks++;
      if (frame_start !== (k == 0)) begin errors++; $display("FAIL scan_fs k=%0d actual=%b", k, frame_start); end
      step;
    end
  endtask

  task automatic test_tearing;
    for (int k = 0; k < 24; k++) begin
      if (k >= 20) begin
        checks++;
        if (seg !== exp_seg(4'd6)) begin errors++; $display("FAIL tear_old k=%0d actual=%h required=%h", k, seg, exp_seg(4'd6)); end
      end
      if (k == 9) s2 = 4'd7;
      step;
    end
    for (int k = 0; k < 24; k++) begin
      if (k >= 20) begin
        checks++;
        if (seg !== exp_seg(4'd7)) begin errors++; $display("FAIL tear_new k=%0d actual=%h required=%h", k, seg, exp_seg(4'd7)); end
      end
      step;
    end
  endtask

  task automatic test_invalid_bcd;
    m1 = 4'hC;
    for (int k = 0; k < 24; k++) begin
      if (k >= 8 && k < 12) begin
        checks++;
        if (seg !== exp_seg(4'd3)) begin errors++; $display("FAIL bcd_pre k=%0d actual=%h required=%h", k, seg, exp_seg(4'd3)); end
      end
      step;
    end
    m1 = 4'd3;
    for (int k = 0; k < 24; k++) begin
      if (k >= 8 && k < 12) begin
        checks++;
        if (an !== 6'b111011) begin errors++; $display("FAIL bcd_an k=%0d actual=%b required=111011", k, an); end
        checks++;
        if (seg !== 7'h7F) begin errors++; $display("FAIL bcd_seg k=%0d actual=%h required=7f", k, seg); end
      end
      step;
    end
  endtask

  task automatic test_enable_gap;
    for (int k = 0; k < 14; k++) begin
      checks++;
      if (an !== exp_an(k / 4)) begin errors++; $display("FAIL gap_pre_an k=%0d actual=%b required=%b", k, an, exp_an(k / 4)); end
      if (k == 13) en = 1'b0;
      step;
    end
    for (int g = 0; g < 10; g++) begin
      checks++;
      if (an !== 6'b111111 || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
        errors++; $display("FAIL gap_idle g=%0d actual an=%b seg=%h dp=%b fs=%b required an=111111 seg=7f dp=1 fs=0", g, an, seg, dp, frame_start);
      end
      if (g == 9) en = 1'b1;
      step;
    end
    for (int k = 14; k < 24; k++) begin
      checks++;
      if (an !== exp_an(k / 4)) begin errors++; $display("FAIL gap_post_an k=%0d actual=%b required=%b", k, an, exp_an(k / 4)); end
      checks++;
      if (frame_start !== 1'b0) begin errors++; $display("FAIL gap_post_fs k=%0d actual=%b required=0", k, frame_start); end
      step;
    end
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL gap_next_fs actual=%b required=1", frame_start); end
  endtask

  task automatic test_blink;
    logic blank;
    logic [3:0] d;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    blink_mask = 6'b110000;
    rst = 1'b0;
    step;
    checks++;
    if (an !== 6'b111111) begin errors++; $display("FAIL midreset_an actual=%b required=111111", an); end
    rst = 1'b1;
    step;
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL midreset_fs actual=%b required=1", frame_start); end
    for (int f = 0; f < 8; f++) begin
`ifdef BLINK_EN
      blank = ((f % 4) >= 2);
`else
      blank = 1'b0;
`endif
      for (int k = 0; k < 24; k++) begin
        if (k < 4) begin
          checks++;
          if (seg !== exp_seg(4'd1)) begin errors++; $display("FAIL blink_h1 f=%0d k=%0d actual=%h required=%h", f, k, seg, exp_seg(4'd1)); end
        end
        if (k >= 16) begin
          d = (k >= 20) ? 4'd6 : 4'd5;
          checks++;
          if (an !== exp_an(k / 4)) begin errors++; $display("FAIL blink_an f=%0d k=%0d actual=%b required=%b", f, k, an, exp_an(k / 4)); end
          checks++;
          if (seg !== (blank ? 7'h7F : exp_seg(d))) begin
            errors++; $display("FAIL blink_seg f=%0d k=%0d actual=%h required=%h", f, k, seg, (blank ? 7'h7F : exp_seg(d)));
          end
        end
        step;
      end
    end
  endtask

  initial begin
    test_reset;
    test_full_scan;
    test_tearing;
    test_invalid_bcd;
    test_enable_gap;
    test_blink;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
